// File: rtl/dmem_arb_pkg.sv
// Shared types and default limits for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DEF_STARVE_LIM = 4;
  localparam int unsigned DEF_LOCK_MAX   = 8;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_DLOCK = 2'd1,
    ST_DREL  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_CORE   = 1'b0,
    OWNER_LOADER = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned W     = 3,
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic full
);

  logic [W-1:0] cnt_q;

  assign full = (cnt_q == W'(LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !full) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store path and
// the loader/debug port, with starvation and burst-length limits.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_LIM = DEF_STARVE_LIM,
  parameter int unsigned LOCK_MAX   = DEF_LOCK_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_stall,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_we,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIM + 1);
  localparam int unsigned LOCK_W   = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  arb_state_e state_q, state_d;
  owner_e     owner;
  logic       gnt_any;
  logic       starve_full;
  logic       lock_last;
  logic       lock_hold;

  // Grant selection from registered state; nothing is granted during reset.
  always_comb begin
    owner   = OWNER_CORE;
    gnt_any = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (d_req && (!c_req || starve_full)) begin
          owner   = OWNER_LOADER;
          gnt_any = 1'b1;
        end else begin
          gnt_any = c_req;
        end
      end
      ST_DLOCK: begin
        owner   = OWNER_LOADER;
        gnt_any = d_req;
      end
      ST_DREL: gnt_any = c_req;
      default: gnt_any = 1'b0;
    endcase
    if (!rst) gnt_any = 1'b0;
  end

  assign c_gnt     = gnt_any && (owner == OWNER_CORE);
  assign d_gnt     = gnt_any && (owner == OWNER_LOADER);
  assign c_stall   = c_req && !c_gnt;
  assign lock_hold = d_gnt && d_lock;

  // A locked loader grant keeps ownership unless it was the last one allowed.
  always_comb begin
    state_d = ST_ARB;
    if (lock_hold) state_d = lock_last ? ST_DREL : ST_DLOCK;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_ARB;
    else      state_q <= state_d;
  end

  // Consecutive contended core grants; full forces the loader in.
  sat_counter #(
    .W     (STARVE_W),
    .LIMIT (STARVE_LIM)
  ) u_starve_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (d_gnt || !d_req || (state_q == ST_DREL)),
    .inc  (c_gnt && d_req),
    .full (starve_full)
  );

  // Locked loader grants already completed in this burst; full marks the
  // current locked grant as the LOCK_MAX-th, so the burst releases after it.
  sat_counter #(
    .W     (LOCK_W),
    .LIMIT (LOCK_MAX - 1)
  ) u_lock_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (!lock_hold),
    .inc  (lock_hold),
    .full (lock_last)
  );

  assign m_addr  = d_gnt ? d_addr  : c_addr;
  assign m_wdata = d_gnt ? d_wdata : c_wdata;
  assign m_we    = (c_gnt && c_we) || (d_gnt && d_we);
  assign c_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a grant-policy model.
module tb_dmem_arbiter;

  localparam int unsigned SL = 4;
  localparam int unsigned LM = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, c_gnt, c_stall;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        d_req, d_we, d_lock, d_gnt;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_we;

  bit [31:0] mem  [256];
  bit [31:0] smem [256];

  int checks = 0;
  int errors = 0;

  // policy model state
  int streak;
  int burst;
  bit release_owed;
  bit e_c, e_d, e_stall, e_we;
  logic [31:0] e_addr, e_wdata, e_rdata;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(SL), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  assign m_rdata = mem[m_addr[7:0]];
  always @(posedge clk) if (m_we) mem[m_addr[7:0]] <= m_wdata;

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(63)) << 2;
  endfunction

  task automatic predict();
    e_c = 1'b0;
    e_d = 1'b0;
    if (rst) begin
      if (release_owed)          e_c = c_req;
      else if (burst > 0)        e_d = d_req;
      else if (c_req && d_req) begin
        if (streak >= int'(SL)) e_d = 1'b1;
        else                    e_c = 1'b1;
      end else begin
        e_c = c_req;
        e_d = d_req;
      end
    end
    e_stall = c_req && !e_c;
    e_we    = (e_c && c_we) || (e_d && d_we);
    e_addr  = e_d ? d_addr : c_addr;
    e_wdata = e_d ? d_wdata : c_wdata;
    e_rdata = smem[e_addr[7:0]];
  endtask

  task automatic model_update();
    if (!rst) begin
      streak = 0;
      burst = 0;
      release_owed = 1'b0;
    end else begin
      if (e_c && c_we) smem[c_addr[7:0]] = c_wdata;
      if (e_d && d_we) smem[d_addr[7:0]] = d_wdata;
      if (release_owed || e_d || !d_req) streak = 0;
      else if (e_c && streak < int'(SL)) streak++;
      if (release_owed) begin
        release_owed = 1'b0;
        burst = 0;
      end else if (e_d && d_lock) begin
        burst++;
        if (burst >= int'(LM)) release_owed = 1'b1;
      end else begin
        burst = 0;
      end
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic dl, input logic [31:0] da,
                       input logic [31:0] dd);
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    d_req = dr; d_we = dw; d_lock = dl; d_addr = da; d_wdata = dd;
    #2;
    predict();
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1, 1, 32'h24, 32'h1234_5678, 1, 1, 1, 32'h40, 32'h0BAD_F00D);
    checks++;
    if ({c_gnt, d_gnt, m_we, c_stall} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_outputs: got gnt/gnt/we/stall %b want 0001", {c_gnt, d_gnt, m_we, c_stall});
    end
    checks++;
    if ({m_addr, m_wdata} !== {32'h24, 32'h1234_5678}) begin
      errors++;
      $display("FAIL reset_mux: got %h/%h want 00000024/12345678", m_addr, m_wdata);
    end
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_core_then_loader();
    idle();
    drive(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 32'h0, 32'h0);
    checks++;
    if ({c_gnt, d_gnt, m_we, c_stall} !== 4'b1010 || m_addr !== 32'h10 || m_wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL core_write: got gnt/gnt/we/stall %b addr %h data %h want 1010 00000010 deadbeef",
               {c_gnt, d_gnt, m_we, c_stall}, m_addr, m_wdata);
    end
    tick();
    drive(0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h10, 32'h0);
    checks++;
    if ({c_gnt, d_gnt, m_we} !== 3'b010 || d_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL loader_read: got gnt %b%b we %b rdata %h want 010 deadbeef", c_gnt, d_gnt, m_we, d_rdata);
    end
    tick();
  endtask

  task automatic test_contention();
    idle();
    for (int i = 0; i < 15; i++) begin
      drive(1, 1'($urandom_range(1)), rand_addr(), $urandom(),
            1, 1'($urandom_range(1)), 0, rand_addr(), $urandom());
      checks++;
      if ({c_gnt, d_gnt, c_stall} !== {(i % 5) != 4, (i % 5) == 4, (i % 5) == 4}) begin
        errors++;
        $display("FAIL contention_pattern cyc %0d: got gnt/gnt/stall %b want %b", i,
                 {c_gnt, d_gnt, c_stall}, {(i % 5) != 4, (i % 5) == 4, (i % 5) == 4});
      end
      checks++;
      if ({m_we, m_addr, m_wdata} !== {e_we, e_addr, e_wdata}) begin
        errors++;
        $display("FAIL contention_mux cyc %0d: got we %b %h/%h want %b %h/%h", i, m_we, m_addr, m_wdata,
                 e_we, e_addr, e_wdata);
      end
      tick();
    end
  endtask

  task automatic test_burst_short();
    logic [31:0] wd [3];
    for (int i = 0; i < 3; i++) wd[i] = $urandom();
    idle();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(i != 0, 0, 32'h80, 32'h0, 1, 1, i != 2, 32'(i * 4), wd[i]);
      else       drive(1, 0, 32'h80, 32'h0, 0, 0, 0, 32'h0, 32'h0);
      checks++;
      if ({c_gnt, d_gnt, c_stall, m_we} !== {e_c, e_d, e_stall, e_we} ||
          {c_gnt, d_gnt} !== {i == 3, i < 3}) begin
        errors++;
        $display("FAIL burst_short cyc %0d: got gnt/gnt/stall/we %b model %b", i,
                 {c_gnt, d_gnt, c_stall, m_we}, {e_c, e_d, e_stall, e_we});
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0, 32'h0, 1, 0, 0, 32'(i * 4), 32'h0);
      checks++;
      if (d_gnt !== 1'b1 || d_rdata !== wd[i]) begin
        errors++;
        $display("FAIL burst_readback %0d: got gnt %b rdata %h want 1 %h", i, d_gnt, d_rdata, wd[i]);
      end
      tick();
    end
  endtask

  task automatic test_burst_long();
    int dcount;
    dcount = 0;
    idle();
    for (int i = 0; i < 20; i++) begin
      drive(i != 0, 0, rand_addr(), 32'h0, 1, 1'($urandom_range(1)), 1, rand_addr(), $urandom());
      if (i < 8) dcount += int'(d_gnt);
      checks++;
      if ({c_gnt, d_gnt} !== {e_c, e_d} || {c_gnt, d_gnt} !== {i >= 8 && i < 13, i < 8 || i >= 13}) begin
        errors++;
        $display("FAIL burst_long cyc %0d: got gnt %b%b model %b%b", i, c_gnt, d_gnt, e_c, e_d);
      end
      checks++;
      if ({m_we, m_addr, m_wdata} !== {e_we, e_addr, e_wdata}) begin
        errors++;
        $display("FAIL burst_long_mux cyc %0d: got we %b %h want %b %h", i, m_we, m_addr, e_we, e_addr);
      end
      tick();
    end
    checks++;
    if (dcount != int'(LM)) begin
      errors++;
      $display("FAIL burst_long_count: got %0d loader grants want %0d", dcount, LM);
    end
    idle();
  endtask

  task automatic test_reset_midlock();
    idle();
    drive(0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h20, 32'h1111_1111);
    tick();
    drive(1, 0, 32'h30, 32'h0, 1, 1, 1, 32'h24, 32'h2222_2222);
    checks++;
    if ({c_gnt, d_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL midlock_hold: got gnt %b%b want 01", c_gnt, d_gnt);
    end
    tick();
    rst = 1'b0;
    drive(1, 1, 32'h30, 32'h3333_3333, 1, 1, 1, 32'h28, 32'h4444_4444);
    checks++;
    if ({c_gnt, d_gnt, m_we, c_stall} !== 4'b0001) begin
      errors++;
      $display("FAIL midlock_reset: got gnt/gnt/we/stall %b want 0001", {c_gnt, d_gnt, m_we, c_stall});
    end
    tick();
    rst = 1'b1;
    drive(1, 0, 32'h28, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    checks++;
    if ({c_gnt, d_gnt, c_stall} !== 3'b100 || c_rdata !== e_rdata || c_rdata === 32'h4444_4444) begin
      errors++;
      $display("FAIL midlock_after: got gnt/gnt/stall %b rdata %h want 100 %h", {c_gnt, d_gnt, c_stall},
               c_rdata, e_rdata);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(99) != 0);
      drive($urandom_range(9) < 7, 1'($urandom_range(1)), rand_addr(), $urandom(),
            1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(9) < 6, rand_addr(), $urandom());
      checks++;
      if ({c_gnt, d_gnt, c_stall, m_we} !== {e_c, e_d, e_stall, e_we}) begin
        errors++;
        $display("FAIL random_gnt cyc %0d: got gnt/gnt/stall/we %b want %b", i,
                 {c_gnt, d_gnt, c_stall, m_we}, {e_c, e_d, e_stall, e_we});
      end
      checks++;
      if ({m_addr, m_wdata} !== {e_addr, e_wdata}) begin
        errors++;
        $display("FAIL random_mux cyc %0d: got %h/%h want %h/%h", i, m_addr, m_wdata, e_addr, e_wdata);
      end
      if ((e_c && !c_we) || (e_d && !d_we)) begin
        checks++;
        if ((e_d ? d_rdata : c_rdata) !== e_rdata) begin
          errors++;
          $display("FAIL random_rdata cyc %0d: got %h want %h", i, e_d ? d_rdata : c_rdata, e_rdata);
        end
      end
      tick();
    end
    rst = 1'b1;
  endtask

  initial begin
    streak = 0;
    burst = 0;
    release_owed = 1'b0;
    rst = 1'b0;
    #1;
    test_reset();
    test_core_then_loader();
    test_contention();
    test_burst_short();
    test_burst_long();
    test_reset_midlock();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
